data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Sequencing controller and two-port round-robin arbiter in front of the single-port `data_memory`. It accepts load/store requests from the CPU datapath (port 0) and the program loader/debug port (port 1) over valid/ready handshakes. It drives the memory's `address`, `writeData`, `memWrite` and `memRead` for exactly one cycle per transaction, and returns a registered response. Each memory access becomes an explicit, single-owner, cycle-bounded event.

## Interface
- `DATA_WIDTH`, 32: data word width; matches memory `data_width`.
- `ADDR_WIDTH`, 32: requester address width; matches memory `address_width`.
- `MEM_SIZE`, 6: log2 of memory depth; the legal word addresses are 0 .. 2^MEM_SIZE-1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `m0_req_valid`, `m1_req_valid`  in  1  request present.
- `m0_req_ready`, `m1_req_ready`  out  1  request accepted this cycle.
- `m0_req_write`, `m1_req_write`  in  1  1 = store, 0 = load.
- `m0_req_addr`, `m1_req_addr`  in  ADDR_WIDTH  word address.
- `m0_req_wdata`, `m1_req_wdata`  in  DATA_WIDTH  store data.
- `m0_rsp_valid`, `m1_rsp_valid`  out  1  response present.
- `m0_rsp_ready`, `m1_rsp_ready`  in  1  response consumed.
- `m0_rsp_rdata`, `m1_rsp_rdata`  out  DATA_WIDTH  load data; 0 for stores and errors.
- `m0_rsp_err`, `m1_rsp_err`  out  1  address out of range.
- `mem_address`  out  ADDR_WIDTH  to memory `address`.
- `mem_writeData`  out  DATA_WIDTH  to memory `writeData`.
- `mem_memWrite`  out  1  to memory `memWrite`.
- `mem_memRead`  out  1  to memory `memRead`.
- `mem_readData`  in  DATA_WIDTH  from memory `readData`.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - Arbitration picks a winner among the valid ports.
  - `mX_req_ready` is asserted combinationally for the winner only.
  - On the handshake, capture write, addr, wdata and the owner index into registers, then go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration is round-robin between the two ports.
  - `last_grant` is updated on each accepted request.
  - On a tie, the port that is not `last_grant` wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - A single valid port always wins.
- ACCESS (exactly 1 cycle):
  - `mem_address` and `mem_writeData` come from the captured registers.
  - For an in-range load, `mem_memRead`=1 and `mem_readData` is registered into the response data.
  - For an in-range store, `mem_memWrite`=1 and the response data is 0.
  - Next state is RESP.
- Range check: an address is out of range when any bit at or above MEM_SIZE is set.
  - Neither strobe is asserted.
  - The response carries `rsp_err`=1 and `rsp_rdata`=0.
- RESP:
  - The owner's `rsp_valid`=1; the other port's `rsp_valid`=0.
  - Response data and error are held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
- Only one transaction is outstanding at a time; neither `req_ready` is asserted outside IDLE.
- Outside ACCESS, `mem_memRead` = `mem_memWrite` = 0. `mem_address` and `mem_writeData` hold their last captured values.
- `mem_memRead` and `mem_memWrite` are never both 1.

## Timing
- Reset values:
  - state IDLE; `last_grant`=1.
  - Both `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - Both memory strobes 0; `mem_address`=0; `mem_writeData`=0.
- Reset wins over every other event in the same cycle. It aborts any transaction in flight:
  - A strobe asserted in ACCESS drops at that edge.
  - A pending response is discarded.
- Latency:
  - Handshake at edge N → ACCESS during cycle N+1 → `rsp_valid` high from edge N+2.
  - Minimum issue interval is 3 cycles when `rsp_ready` is held high.
- The memory strobe is high for exactly one clock per in-range transaction.
- `req_ready` depends combinationally on both `req_valid`s and on state. No input-to-output path exists on the memory side.
- A request that drops `req_valid` before its handshake is never issued.
- Back-to-back behaviour: with both ports continuously valid, grants alternate 0,1,0,1…

## Structure
- Package `data_mem_arb_pkg` holds:
  - The state enum (IDLE, ACCESS, RESP).
  - Port index constants `PORT_CPU`=0 and `PORT_DBG`=1.
- Sub-module `rr_arbiter_2` takes the two valids, `last_grant` and an enable, and returns a one-hot grant. It is combinational, with `last_grant` kept in the parent.
- Response registers are shared, and are steered to the owner port by the captured owner index.

## Test plan
- Reset mid-ACCESS (`rst_n`=0 during an ACCESS store) → strobes 0 next edge, state IDLE, `rsp_valid`=0, `last_grant`=1.
- Store then load:
  - Port 0 stores 0xDEADBEEF @5 → `mem_memWrite` pulses 1 cycle, response rdata 0.
  - Port 0 then loads @5 → rdata 0xDEADBEEF at cycle N+2.
- Simultaneous requests: both ports valid for 4 transactions → grants 0,1,0,1, with each response routed only to its requester.
- Out-of-range access: port 1 loads @64 (MEM_SIZE=6) → no strobe, `rsp_err`=1, rdata 0.
- Response backpressure: `rsp_ready` low for 5 cycles → `rsp_valid` and data stable, no `req_ready` asserted, then IDLE the cycle after `rsp_ready`.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data memory arbiter.
// Holds the FSM state enum and requester port indices.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports: en_i gate, valid_i {p1,p0}, last_grant_i, grant_o one-hot.
module rr_arbiter_2 (
  input  logic       en_i,
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        // tie: the port not served last time wins
        2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin sequencer for the single-port data memory.
// Ports: m0/m1 req+rsp handshakes, mem_* strobes/data, clk, rst_n.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_write,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_rsp_valid,
  input  logic                  m0_rsp_ready,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  output logic                  m0_rsp_err,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_write,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_rsp_valid,
  input  logic                  m1_rsp_ready,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  m1_rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  output logic                  mem_memWrite,
  output logic                  mem_memRead,
  input  logic [DATA_WIDTH-1:0] mem_readData
);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [1:0] grant;
  logic       accept;
  logic       in_range;
  logic       own_rdy;
  logic       sel0, sel1;

  rr_arbiter_2 u_arb (
    .en_i         (state_q == IDLE),
    .valid_i      ({m1_req_valid, m0_req_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign accept   = |grant;
  assign in_range = (addr_q >> MEM_SIZE) == '0;
  assign own_rdy  = (owner_q == PORT_DBG) ? m1_rsp_ready
                                          : m0_rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (own_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_req_ready = grant[0];
    m1_req_ready = grant[1];
    mem_memRead  = 1'b0;
    mem_memWrite = 1'b0;
    if (state_q == ACCESS && in_range) begin
      mem_memWrite = wr_q;
      mem_memRead  = !wr_q;
    end
    sel0 = (state_q == RESP) && (owner_q == PORT_CPU);
    sel1 = (state_q == RESP) && (owner_q == PORT_DBG);
    m0_rsp_valid = sel0;
    m1_rsp_valid = sel1;
    m0_rsp_rdata = sel0 ? rdata_q : '0;
    m1_rsp_rdata = sel1 ? rdata_q : '0;
    m0_rsp_err   = sel0 & err_q;
    m1_rsp_err   = sel1 & err_q;
  end

  assign mem_address   = addr_q;
  assign mem_writeData = wdata_q;

  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    if (accept) begin
      owner_d      = grant[1] ? PORT_DBG : PORT_CPU;
      last_grant_d = owner_d;
      wr_d    = grant[1] ? m1_req_write : m0_req_write;
      addr_d  = grant[1] ? m1_req_addr  : m0_req_addr;
      wdata_d = grant[1] ? m1_req_wdata : m0_req_wdata;
    end
    if (state_q == ACCESS) begin
      rdata_d = (in_range && !wr_q) ? mem_readData : '0;
      err_d   = !in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= PORT_DBG;
      owner_q      <= PORT_CPU;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural memory.
// Drivers feed per-port request queues; a negedge monitor checks.
module tb_data_mem_arbiter;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;
  } req_t;

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
  logic [31:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;
  logic        rr0 = 1'b0, rr1 = 1'b0;
  logic        rdy0, rdy1, rv0, rv1, e0, e1;
  logic [31:0] rd0, rd1;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_memWrite, mem_memRead;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  req_t q0[$];
  req_t q1[$];
  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  bit   rst_seen = 1'b1;
  int   phase = 0;
  logic mlast = 1'b1;
  bit   rsp_rand = 1'b0;
  logic rsp_hold = 1'b1;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MEM_SIZE   (6)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m0_req_valid  (v0),
    .m0_req_ready  (rdy0),
    .m0_req_write  (w0),
    .m0_req_addr   (a0),
    .m0_req_wdata  (d0),
    .m0_rsp_valid  (rv0),
    .m0_rsp_ready  (rr0),
    .m0_rsp_rdata  (rd0),
    .m0_rsp_err    (e0),
    .m1_req_valid  (v1),
    .m1_req_ready  (rdy1),
    .m1_req_write  (w1),
    .m1_req_addr   (a1),
    .m1_req_wdata  (d1),
    .m1_rsp_valid  (rv1),
    .m1_rsp_ready  (rr1),
    .m1_rsp_rdata  (rd1),
    .m1_rsp_err    (e1),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_memWrite  (mem_memWrite),
    .mem_memRead   (mem_memRead),
    .mem_readData  (mem_readData)
  );

  // behavioural data_memory: async read, write on clock edge
  assign mem_readData = mem[mem_address[5:0]];

  always @(posedge clk) begin
    if (mem_memWrite) mem[mem_address[5:0]] <= mem_writeData;
    rst_seen <= !rst_n;
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // reference model: result decided when the request is accepted
  task automatic issue(input int p, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   inr;
    inr     = (a < 64);
    e.port  = p;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = d;
    e.err   = !inr;
    e.rdata = (!wr && inr) ? ref_mem[a[5:0]] : 32'd0;
    if (wr && inr) ref_mem[a[5:0]] = d;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (v0 && rdy0) issue(0, w0, a0, d0);
      if (v1 && rdy1) issue(1, w1, a1, d1);
    end
  end

  always @(negedge clk) begin
    int   ph;
    bit   hasw;
    logic win;
    bit   inr;
    exp_t e;
    if (rst_seen) begin
      chk("rst_rsp_valid", 32'({rv0, rv1}), 32'd0);
      chk("rst_rsp_err", 32'({e0, e1}), 32'd0);
      chk("rst_rsp_rdata", rd0 | rd1, 32'd0);
      chk("rst_strobes", 32'({mem_memRead, mem_memWrite}), 32'd0);
      chk("rst_mem_address", mem_address, 32'd0);
      chk("rst_mem_wdata", mem_writeData, 32'd0);
      phase = 0;
      mlast = 1'b1;
      if (!rst_n) exp_q.delete();
    end
    ph = phase;
    if (ph == 1) begin
      if (exp_q.size() == 0) begin
        chk("acc_expect_queue", 32'd0, 32'd1);
      end else begin
        e   = exp_q[0];
        inr = (e.addr < 64);
        chk("acc_memWrite", 32'(mem_memWrite), 32'(e.wr && inr));
        chk("acc_memRead", 32'(mem_memRead), 32'(!e.wr && inr));
        chk("acc_address", mem_address, e.addr);
        if (e.wr) chk("acc_wdata", mem_writeData, e.wdata);
      end
      phase = 2;
    end else begin
      chk("idle_strobes", 32'({mem_memRead, mem_memWrite}), 32'd0);
    end
    if (ph == 2) begin
      if (exp_q.size() == 0) begin
        chk("rsp_expect_queue", 32'd0, 32'd1);
        phase = 0;
      end else begin
        e = exp_q[0];
        chk("rsp_valid_owner", 32'(e.port == 0 ? rv0 : rv1), 32'd1);
        chk("rsp_valid_other", 32'(e.port == 0 ? rv1 : rv0), 32'd0);
        chk("rsp_rdata", e.port == 0 ? rd0 : rd1, e.rdata);
        chk("rsp_err", 32'(e.port == 0 ? e0 : e1), 32'(e.err));
        if ((e.port == 0 ? rr0 : rr1) && rst_n) begin
          void'(exp_q.pop_front());
          phase = 0;
        end
      end
    end else begin
      chk("rsp_valid_quiet", 32'({rv0, rv1}), 32'd0);
    end
    if (ph == 0) begin
      hasw = v0 || v1;
      win  = (v0 && v1) ? !mlast : v1;
      chk("req_ready0", 32'(rdy0), 32'(hasw && !win));
      chk("req_ready1", 32'(rdy1), 32'(hasw && win));
      if (hasw && rst_n) begin
        mlast = win;
        phase = 1;
      end
    end else begin
      chk("req_ready_busy", 32'({rdy0, rdy1}), 32'd0);
    end
  end

  always @(posedge clk) begin
    #1;
    rr0 = rsp_rand ? 1'($urandom_range(0, 1)) : rsp_hold;
    rr1 = rsp_rand ? 1'($urandom_range(0, 1)) : rsp_hold;
  end

  initial begin
    bit   took;
    int   cnt;
    req_t r;
    cnt = 0;
    forever begin
      @(negedge clk);
      took = v0 && rdy0 && rst_n;
      @(posedge clk);
      #1;
      if (took) v0 = 1'b0;
      if (!v0 && q0.size() > 0) begin
        if (cnt < q0[0].gap) cnt++;
        else begin
          cnt = 0;
          r   = q0.pop_front();
          w0  = r.wr;
          a0  = r.addr;
          d0  = r.data;
          v0  = 1'b1;
        end
      end
    end
  end

  initial begin
    bit   took;
    int   cnt;
    req_t r;
    cnt = 0;
    forever begin
      @(negedge clk);
      took = v1 && rdy1 && rst_n;
      @(posedge clk);
      #1;
      if (took) v1 = 1'b0;
      if (!v1 && q1.size() > 0) begin
        if (cnt < q1[0].gap) cnt++;
        else begin
          cnt = 0;
          r   = q1.pop_front();
          w1  = r.wr;
          a1  = r.addr;
          d1  = r.data;
          v1  = 1'b1;
        end
      end
    end
  end

  task automatic push(input int p, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input int gap);
    req_t r;
    r.wr   = wr;
    r.addr = a;
    r.data = d;
    r.gap  = gap;
    if (p == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !v0 && !v1 &&
                 phase == 0 && exp_q.size() == 0) && n < lim);
    if (n >= lim) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: not idle after %0d cycles", n);
    end
  endtask

  initial begin
    int          n;
    bit          hit;
    logic [31:0] a;
    logic [31:0] edge_addr [5];
    edge_addr[0] = 32'd63;
    edge_addr[1] = 32'd64;
    edge_addr[2] = 32'd0;
    edge_addr[3] = 32'h8000_0000;
    edge_addr[4] = 32'd127;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    push(0, 1'b1, 32'd5, 32'hDEADBEEF, 0);
    wait_idle(50);
    push(0, 1'b0, 32'd5, 32'd0, 0);
    wait_idle(50);

    rsp_hold = 1'b0;
    push(0, 1'b0, 32'd5, 32'd0, 0);
    n = 0;
    while (!rv0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL bp_wait: rsp_valid never rose");
    end
    repeat (5) @(posedge clk);
    #2 rsp_hold = 1'b1;
    wait_idle(50);

    push(1, 1'b0, 32'd64, 32'd0, 0);
    wait_idle(50);

    for (int i = 0; i < 2; i++) begin
      push(0, 1'b1, 32'(10 + i), $urandom, 0);
      push(1, 1'b0, 32'(10 + i), 32'd0, 0);
    end
    wait_idle(100);

    push(0, 1'b1, 32'd9, 32'hCAFE_0009, 0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (mem_memWrite) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL rst_access_wait: no write strobe seen");
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_idle(50);

    rsp_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) a = edge_addr[$urandom_range(0, 4)];
      else if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 63));
      push(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
           $urandom, int'($urandom_range(0, 3)));
    end
    wait_idle(6000);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
